// File: rtl/rom_fetch_arbiter_if.sv
// Fetch/debug request ports and the instruction-ROM port shared by the arbiter and its users.
// Latency: none, wires only.
// Backpressure: each requester holds Req/Addr until it sees its one-cycle Ack.
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              IF_Req;
    logic [ADDR_W-1:0] IF_Addr;
    logic              IF_Ack;
    logic [31:0]       IF_Data;
    logic              DBG_Req;
    logic [ADDR_W-1:0] DBG_Addr;
    logic              DBG_Ack;
    logic [31:0]       DBG_Data;
    logic [ADDR_W-1:0] ROM_Address;
    logic [31:0]       ROM_Data;
    logic [1:0]        Grant;

    // Arbiter side.
    modport slave (
        input  IF_Req, IF_Addr, DBG_Req, DBG_Addr, ROM_Data,
        output IF_Ack, IF_Data, DBG_Ack, DBG_Data, ROM_Address, Grant
    );

    // Requester / ROM side.
    modport master (
        output IF_Req, IF_Addr, DBG_Req, DBG_Addr, ROM_Data,
        input  IF_Ack, IF_Data, DBG_Ack, DBG_Data, ROM_Address, Grant
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates CPU fetch and debug readback onto one combinational ROM; fetch has priority.
// Latency: request sampled at edge N, Ack and Data after edge N+1; one word per 2 cycles.
// Backpressure: requester holds Req/Addr until Ack; ROM_ARB_STARVE_EN adds a debug anti-starvation counter.
module rom_fetch_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    rom_fetch_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_XFER  = 2'd1,
        DBG_XFER = 2'd2
    } state_t;

    state_t            state;
    logic              pick_if;
    logic              pick_dbg;
    logic              starve_force;
    logic [ADDR_W-1:0] win_addr;

    // The counter is 3 bits wide, so the limit must fit in it.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("rom_fetch_arbiter: STARVE_LIMIT must be 1..7");
    end

`ifdef ROM_ARB_STARVE_EN
    logic [2:0] starve_cnt;

    // Debug has waited through STARVE_LIMIT fetch grants: the next grant is its.
    assign starve_force = bus.DBG_Req && (starve_cnt >= 3'(STARVE_LIMIT));

    // Count fetch grants made while debug waits; any debug grant or idle debug clears it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= 3'd0;
        end else if (!bus.DBG_Req) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE && pick_dbg) begin
            starve_cnt <= 3'd0;
        end else if (state == IDLE && pick_if && starve_cnt != 3'd7) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Winner selection for a decision in IDLE: fetch first unless debug is being starved.
    always_comb begin
        pick_if  = bus.IF_Req && !starve_force;
        pick_dbg = bus.DBG_Req && !pick_if;
        win_addr = pick_if ? bus.IF_Addr : bus.DBG_Addr;
    end

    // Grant/transfer FSM; every output is a register so Grant, Ack and Data are glitch-free.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            bus.IF_Ack      <= 1'b0;
            bus.DBG_Ack     <= 1'b0;
            bus.IF_Data     <= 32'd0;
            bus.DBG_Data    <= 32'd0;
            bus.ROM_Address <= '0;
            bus.Grant       <= 2'b00;
        end else begin
            bus.IF_Ack  <= 1'b0;
            bus.DBG_Ack <= 1'b0;
            case (state)
                IDLE: begin
                    // ROM_Address only moves on a grant, so it holds while idle.
                    if (pick_if) begin
                        bus.ROM_Address <= win_addr;
                        bus.Grant       <= 2'b01;
                        state           <= IF_XFER;
                    end else if (pick_dbg) begin
                        bus.ROM_Address <= win_addr;
                        bus.Grant       <= 2'b10;
                        state           <= DBG_XFER;
                    end
                end
                IF_XFER: begin
                    // The requester still shows the served request here, so always
                    // return to IDLE; a Req held through the Ack cycle is a new request.
                    bus.IF_Data <= bus.ROM_Data;
                    bus.IF_Ack  <= 1'b1;
                    bus.Grant   <= 2'b00;
                    state       <= IDLE;
                end
                DBG_XFER: begin
                    bus.DBG_Data <= bus.ROM_Data;
                    bus.DBG_Ack  <= 1'b1;
                    bus.Grant    <= 2'b00;
                    state        <= IDLE;
                end
                default: begin
                    bus.Grant <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
